data_mem_responder: RTL and testbench

- Multi-cycle data-memory target that answers the load/store requests the pipeline's MEM stage issues.
- Uses a valid/ready request channel and a one-cycle response pulse, with a programmable fixed access latency.
- Has word-organised storage, byte-enable writes, and alignment/range error reporting.
- Drives a stall signal so the pipeline holds its MEM-stage request until the response arrives.

---
 rtl/data_mem_responder_if.sv | 24 ++
 rtl/data_mem_responder.sv | 94 +++++++++
 tb/tb_data_mem_responder.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Request/response channel between the pipeline MEM stage (master) and the
// data-memory responder (slave).
interface data_mem_responder_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_write_i;
    logic [3:0]  req_be_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;
    logic        stall_o;

    modport master (
        output req_valid_i, req_write_i, req_be_i, req_addr_i, req_wdata_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, stall_o
    );

    modport slave (
        input  req_valid_i, req_write_i, req_be_i, req_addr_i, req_wdata_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, stall_o
    );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory target for MEM-stage loads/stores: fixed programmable
// latency, byte-enable stores, alignment/range error reporting.
module data_mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 3
) (
    input logic                 clk_i,
    input logic                 rst_i,
    data_mem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;

    logic        req_write_p0;
    logic [3:0]  req_be_p0;
    logic [31:0] req_addr_p0;
    logic [31:0] req_wdata_p0;

    logic [31:0] rdata_p1;
    logic        err_p1;
    logic        vld_p1;

    logic [31:0] mem [DEPTH];

    logic          accept;
    logic          commit;
    logic          commit_err;
    logic [AW-1:0] word_idx;

    function automatic logic addr_fault(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(DEPTH));
    endfunction

    assign accept     = bus.req_valid_i && (state == IDLE);
    assign commit     = (state == BUSY) && (cnt == 4'd0);
    assign commit_err = addr_fault(req_addr_p0);
    assign word_idx   = req_addr_p0[AW+1:2];
    assign vld_p1     = (state == RESP);

    assign bus.req_ready_o  = (state == IDLE);
    assign bus.resp_valid_o = vld_p1;
    assign bus.resp_rdata_o = rdata_p1;
    assign bus.resp_err_o   = err_p1;
    assign bus.stall_o      = bus.req_valid_i & ~vld_p1;

    // p0: request latched at acceptance, held through BUSY; p1: committed response
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            rdata_p1 <= '0;
            err_p1   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_write_p0 <= bus.req_write_i;
                        req_be_p0    <= bus.req_be_i;
                        req_addr_p0  <= bus.req_addr_i;
                        req_wdata_p0 <= bus.req_wdata_i;
                        cnt          <= 4'(LATENCY - 1);
                        state        <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state    <= RESP;
                        err_p1   <= commit_err;
                        rdata_p1 <= (!commit_err && !req_write_p0) ? mem[word_idx] : '0;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Reset at the commit edge must suppress the store, so rst_i gates the write.
    always_ff @(posedge clk_i) begin
        if (commit && !rst_i && !commit_err && req_write_p0) begin
            for (int b = 0; b < 4; b++) begin
                if (req_be_p0[b]) begin
                    mem[word_idx][8*b +: 8] <= req_wdata_p0[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (LATENCY 3, 1, 15) share one
// stimulus bus; only the selected instance sees req_valid.
module tb_data_mem_responder;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [3:0]  req_be;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    int          sel;

    logic        rdy [3];
    logic        rv  [3];
    logic        st  [3];
    logic        er  [3];
    logic [31:0] rd  [3];

    int lat_of [3] = '{3, 1, 15};
    int errors = 0;
    int checks = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 3 : ((g == 1) ? 1 : 15);
        data_mem_responder_if bus ();
        assign bus.req_valid_i = req_valid & (sel == g);
        assign bus.req_write_i = req_write;
        assign bus.req_be_i    = req_be;
        assign bus.req_addr_i  = req_addr;
        assign bus.req_wdata_i = req_wdata;
        assign rdy[g] = bus.req_ready_o;
        assign rv[g]  = bus.resp_valid_o;
        assign st[g]  = bus.stall_o;
        assign er[g]  = bus.resp_err_o;
        assign rd[g]  = bus.resp_rdata_o;
        data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
            .clk_i (clk),
            .rst_i (rst),
            .bus   (bus)
        );
    end

    typedef struct {
        logic        w;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic [31:0] model_mem [3][16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One complete request; returns the response and checks handshake and timing.
    task automatic do_req(input int g, input logic w, input logic [3:0] be,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rdata, output logic err);
        int n;
        bit busy_ok;
        bit ok;
        sel = g; req_write = w; req_be = be; req_addr = a; req_wdata = d;
        req_valid = 1'b1;
        #1;
        chk("stall_raise", 32'(st[g]), 32'd1);
        chk("ready_idle", 32'(rdy[g]), 32'd1);
        n = 0; busy_ok = 1'b1; ok = 1'b0; rdata = '0; err = 1'b0;
        while (n < 40 && !ok) begin
            @(posedge clk); #1; n++;
            if (rdy[g]) busy_ok = 1'b0;
            if (rv[g]) begin
                ok = 1'b1; rdata = rd[g]; err = er[g];
                chk("stall_in_resp", 32'(st[g]), 32'd0);
            end
        end
        chk("resp_seen", 32'(ok), 32'd1);
        chk("latency", 32'(n), 32'(lat_of[g] + 1));
        chk("ready_low_busy_resp", 32'(busy_ok), 32'd1);
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("resp_one_cycle", 32'(rv[g]), 32'd0);
    endtask

    function automatic logic exp_fault(input logic [31:0] a);
        return (a % 4 != 0) || ((a / 4) >= DEPTH);
    endfunction

    task automatic b2b(input int g);
        int cyc, accepts, resps, last, first_resp;
        bit pre_ready;
        sel = g; req_write = 1'b0; req_be = 4'h0; req_addr = 32'h0; req_wdata = '0;
        req_valid = 1'b1;
        cyc = 0; accepts = 0; resps = 0; last = -1; first_resp = -1;
        #1;
        while (resps < 3 && cyc < 200) begin
            pre_ready = rdy[g];
            @(posedge clk); #1; cyc++;
            if (pre_ready) begin
                accepts++;
                if (last >= 0) chk($sformatf("b2b_spacing_l%0d", lat_of[g]), 32'(cyc - last), 32'(lat_of[g] + 2));
                last = cyc;
            end
            if (rv[g]) begin
                resps++;
                if (first_resp < 0) first_resp = cyc;
            end
        end
        req_valid = 1'b0;
        chk("b2b_accepts", 32'(accepts), 32'd3);
        chk("b2b_resps", 32'(resps), 32'd3);
        chk("b2b_first_resp", 32'(first_resp), 32'(lat_of[g] + 1));
        @(posedge clk); #1;
        chk("b2b_idle_after", 32'(rdy[g]), 32'd1);
    endtask

    initial begin
        vec_t        vecs[$];
        logic [31:0] r;
        logic        e;
        bit          quiet;

        vecs.push_back('{1'b1, 4'hF, 32'h0000_0010, 32'hDEADBEEF, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 4'h0, 32'h0000_0010, 32'h0,        32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b1, 4'hF, 32'h0000_0020, 32'h11223344, 32'h0, 1'b0});
        vecs.push_back('{1'b1, 4'h5, 32'h0000_0020, 32'hAABBCCDD, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 4'hF, 32'h0000_0020, 32'h0,        32'h11BB33DD, 1'b0});
        vecs.push_back('{1'b1, 4'hF, 32'h0000_0000, 32'h01234567, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 4'hF, 32'h0000_0022, 32'h0,        32'h0, 1'b1});
        vecs.push_back('{1'b1, 4'hF, 32'h0000_1000, 32'hFFFFFFFF, 32'h0, 1'b1});
        vecs.push_back('{1'b0, 4'h0, 32'h0000_0000, 32'h0,        32'h01234567, 1'b0});
        vecs.push_back('{1'b1, 4'h0, 32'h0000_0010, 32'h55555555, 32'h0, 1'b0});
        vecs.push_back('{1'b1, 4'hF, 32'h0000_0030, 32'h00000000, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 4'hF, 32'h0000_0010, 32'h0,        32'hDEADBEEF, 1'b0});

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_be = '0;
        req_addr = '0; req_wdata = '0; sel = 0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("rst_ready_%0d", g), 32'(rdy[g]), 32'd1);
            chk($sformatf("rst_resp_valid_%0d", g), 32'(rv[g]), 32'd0);
            chk($sformatf("rst_stall_%0d", g), 32'(st[g]), 32'd0);
            chk($sformatf("rst_rdata_%0d", g), rd[g], 32'd0);
            chk($sformatf("rst_err_%0d", g), 32'(er[g]), 32'd0);
        end

        foreach (vecs[i]) begin
            do_req(0, vecs[i].w, vecs[i].be, vecs[i].addr, vecs[i].wdata, r, e);
            chk($sformatf("vec%0d_rdata", i), r, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
        end

        // Response registers hold after the pulse.
        repeat (3) @(posedge clk);
        #1;
        chk("rdata_hold", rd[0], 32'hDEADBEEF);
        chk("err_hold", 32'(er[0]), 32'd0);

        // Reset coinciding with the commit edge: no response, no write.
        sel = 0; req_write = 1'b1; req_be = 4'hF; req_addr = 32'h30; req_wdata = 32'hCAFEF00D;
        req_valid = 1'b1;
        repeat (lat_of[0]) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0;
        quiet = (rv[0] == 1'b0);
        repeat (6) begin
            @(posedge clk); #1;
            if (rv[0]) quiet = 1'b0;
        end
        chk("rst_commit_no_resp", 32'(quiet), 32'd1);
        do_req(0, 1'b0, 4'hF, 32'h30, 32'h0, r, e);
        chk("rst_commit_no_write", r, 32'h0);

        // Reset while BUSY on the long-latency instance abandons the request.
        sel = 2; req_write = 1'b0; req_addr = 32'h0; req_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0;
        quiet = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (rv[2]) quiet = 1'b0;
        end
        chk("rst_busy_no_resp", 32'(quiet), 32'd1);
        chk("rst_busy_ready", 32'(rdy[2]), 32'd1);

        // Reset together with req_valid: nothing accepted.
        sel = 0; req_valid = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0;
        chk("rst_valid_ready", 32'(rdy[0]), 32'd1);
        quiet = 1'b1;
        repeat (lat_of[0] + 3) begin
            @(posedge clk); #1;
            if (rv[0]) quiet = 1'b0;
        end
        chk("rst_valid_no_accept", 32'(quiet), 32'd1);

        for (int g = 0; g < 3; g++) b2b(g);

        // Randomized traffic against a word-array reference model.
        for (int g = 0; g < 3; g++) begin
            for (int w = 0; w < 16; w++) begin
                model_mem[g][w] = $urandom;
                do_req(g, 1'b1, 4'hF, 32'(w * 4), model_mem[g][w], r, e);
                chk("init_err", 32'(e), 32'd0);
            end
            for (int t = 0; t < 30; t++) begin
                logic        w_op;
                logic [3:0]  be;
                logic [31:0] a, d, exp_r, mask;
                logic        exp_e;
                int          k;
                k = $urandom_range(0, 9);
                w_op = 1'($urandom_range(0, 1));
                be = 4'($urandom_range(0, 15));
                d = $urandom;
                if (k < 7)      a = 32'($urandom_range(0, 15) * 4);
                else if (k < 8) a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
                else if (k < 9) a = 32'(DEPTH * 4 + $urandom_range(0, 4000) * 4);
                else            a = ($urandom | 32'h8000_0000) & 32'hFFFF_FFFC;
                exp_e = exp_fault(a);
                exp_r = 32'h0;
                if (!exp_e) begin
                    if (w_op) begin
                        mask = 32'h0;
                        for (int b = 0; b < 4; b++) if (be[b]) mask = mask + (32'hFF << (8 * b));
                        model_mem[g][a / 4] = (model_mem[g][a / 4] & ~mask) | (d & mask);
                    end else begin
                        exp_r = model_mem[g][a / 4];
                    end
                end
                do_req(g, w_op, be, a, d, r, e);
                chk($sformatf("rand_l%0d_rdata_a%h", lat_of[g], a), r, exp_r);
                chk($sformatf("rand_l%0d_err_a%h", lat_of[g], a), 32'(e), 32'(exp_e));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
